// File: rtl/cache_defs.sv
// Shared definitions for the data cache: address field widths, line geometry,
// FSM state encoding and a word-select helper for 64-bit lines.
package cache_defs;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int OFFSET_BITS    = 2;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_WIDTH     = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  // Word <off> of a line; word0 lives in bits [15:0].
  function automatic logic [DATA_W-1:0] line_word(input logic [LINE_WIDTH-1:0] line,
                                                  input logic [OFFSET_BITS-1:0] off);
    return line[off*DATA_W +: DATA_W];
  endfunction
endpackage

// File: rtl/data_cache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache.
//   rd_index            -> rd_valid, rd_tag, rd_line  (combinational read port)
//   line_we/line_*      whole-line fill, sets valid
//   word_we/word_*      single-word update at wr_index (valid untouched)
// Only the valid bits are reset (asynchronously); tag and data are not.
module data_cache_line_array
  import cache_defs::*;
#(
  parameter int INDEX_BITS = 2
) (
  input  logic                                     Clk,
  input  logic                                     Reset_N,
  input  logic [INDEX_BITS-1:0]                    rd_index,
  output logic                                     rd_valid,
  output logic [ADDR_W-INDEX_BITS-OFFSET_BITS-1:0] rd_tag,
  output logic [LINE_WIDTH-1:0]                    rd_line,
  input  logic [INDEX_BITS-1:0]                    wr_index,
  input  logic                                     line_we,
  input  logic [ADDR_W-INDEX_BITS-OFFSET_BITS-1:0] line_tag,
  input  logic [LINE_WIDTH-1:0]                    line_data,
  input  logic                                     word_we,
  input  logic [OFFSET_BITS-1:0]                   word_offset,
  input  logic [DATA_W-1:0]                        word_data
);
  localparam int NUM_LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS  = ADDR_W - INDEX_BITS - OFFSET_BITS;

  logic [NUM_LINES-1:0]                                  valid_q, valid_d;
  logic [NUM_LINES-1:0][TAG_BITS-1:0]                    tag_q, tag_d;
  logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][DATA_W-1:0]  data_q, data_d;

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (line_we) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = line_tag;
      data_d[wr_index]  = line_data;
    end
    if (word_we) begin
      data_d[wr_index][word_offset] = word_data;
    end
  end

  // Reset_N is active-high despite its name.
  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  always_ff @(posedge Clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
//   d_*          MEM-stage data port; d_stall freezes the pipeline
//   m_*          main-memory port; m_ready is a one-cycle completion pulse
//   access_count completed accesses, hit_count read hits (both wrap)
// Read hits return data combinationally in IDLE. Read misses fetch a full
// 4-word line; writes always go to memory and update the cache on a hit only.
module data_cache
  import cache_defs::*;
#(
  parameter int INDEX_BITS = 2
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [ADDR_W-1:0]     d_address,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_stall,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  input  logic                  m_ready,
  output logic [15:0]           access_count,
  output logic [15:0]           hit_count
);
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [15:0]         access_count_q, access_count_d;
  logic [15:0]         hit_count_q, hit_count_d;

  logic [ADDR_W-1:0]     lookup_addr;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [LINE_WIDTH-1:0] rd_line;
  logic                  hit;
  logic                  line_we, word_we;

  // In IDLE the lookup follows the live request; once a transaction is in
  // flight it uses the captured address, so a dropped request cannot corrupt
  // the fill or the write-hit update.
  assign lookup_addr = (state_q == IDLE) ? d_address : req_addr_q;
  assign hit = rd_valid && (rd_tag == lookup_addr[ADDR_W-1:INDEX_BITS+OFFSET_BITS]);

  data_cache_line_array #(.INDEX_BITS(INDEX_BITS)) u_lines (
    .Clk        (Clk),
    .Reset_N    (Reset_N),
    .rd_index   (lookup_addr[OFFSET_BITS +: INDEX_BITS]),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .wr_index   (req_addr_q[OFFSET_BITS +: INDEX_BITS]),
    .line_we    (line_we),
    .line_tag   (req_addr_q[ADDR_W-1:INDEX_BITS+OFFSET_BITS]),
    .line_data  (m_rdata),
    .word_we    (word_we),
    .word_offset(req_addr_q[OFFSET_BITS-1:0]),
    .word_data  (m_wdata_q)
  );

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    d_stall     = 1'b0;
    d_rdata     = '0;
    line_we     = 1'b0;
    word_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Write wins if both strobes are (illegally) raised together.
        if (d_writeM) begin
          d_stall     = 1'b1;
          state_d     = WR_THRU;
          req_addr_d  = d_address;
          m_address_d = d_address;
          m_wdata_d   = d_wdata;
        end else if (d_readM) begin
          if (hit) begin
            d_rdata = line_word(rd_line, d_address[OFFSET_BITS-1:0]);
          end else begin
            d_stall     = 1'b1;
            state_d     = RD_MISS;
            req_addr_d  = d_address;
            m_address_d = {d_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
      end
      RD_MISS: begin
        d_stall = !m_ready;
        if (m_ready) begin
          // Forward the requested word straight from the returning line.
          d_rdata = line_word(m_rdata, req_addr_q[OFFSET_BITS-1:0]);
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      WR_THRU: begin
        d_stall = !m_ready;
        if (m_ready) begin
          word_we = hit;  // no allocate on a write miss
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    access_count_d = access_count_q;
    if ((d_readM || d_writeM) && !d_stall) access_count_d = access_count_q + 16'd1;
    hit_count_d = hit_count_q;
    if (state_q == IDLE && d_readM && !d_writeM && hit) hit_count_d = hit_count_q + 16'd1;
  end

  // Strobes decode from state so an asynchronous reset drops them at once.
  assign m_readM      = (state_q == RD_MISS);
  assign m_writeM     = (state_q == WR_THRU);
  assign m_address    = m_address_q;
  assign m_wdata      = m_wdata_q;
  assign access_count = access_count_q;
  assign hit_count    = hit_count_q;

  always_ff @(posedge Clk or posedge Reset_N) begin
    if (Reset_N) begin
      state_q        <= IDLE;
      req_addr_q     <= '0;
      m_address_q    <= '0;
      m_wdata_q      <= '0;
      access_count_q <= '0;
      hit_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      m_address_q    <= m_address_d;
      m_wdata_q      <= m_wdata_d;
      access_count_q <= access_count_d;
      hit_count_q    <= hit_count_d;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        d_readM, d_writeM;
  logic [15:0] d_address, d_wdata, d_rdata;
  logic        d_stall;
  logic        m_readM, m_writeM;
  logic [15:0] m_address, m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;
  logic [15:0] access_count, hit_count;

  always #5 Clk = ~Clk;

  data_cache dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_stall(d_stall),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .access_count(access_count), .hit_count(hit_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          lat = 1, mcnt = 0, mem_reads = 0, mem_writes = 0;
  bit          mem_en = 0;
  logic [15:0] cur_addr = '0, cur_wdata = '0;
  logic [15:0] lbase;

  // Responds m_ready in the lat-th cycle the strobe is seen.
  always @(posedge Clk) begin
    #2;
    if (mem_en) begin
      if (m_ready) begin
        m_ready = 1'b0;
        mcnt    = 0;
        m_rdata = {$urandom, $urandom};
      end else if (m_readM || m_writeM) begin
        chk("m_rd_wr_excl", {63'd0, m_readM & m_writeM}, 64'd0);
        if (m_readM) chk("m_rd_addr", {48'd0, m_address}, {48'd0, cur_addr[15:2], 2'b00});
        else begin
          chk("m_wr_addr", {48'd0, m_address}, {48'd0, cur_addr});
          chk("m_wdata", {48'd0, m_wdata}, {48'd0, cur_wdata});
        end
        if (mcnt == 0) begin
          if (m_readM) mem_reads++;
          else         mem_writes++;
        end
        if (mcnt >= lat - 1) begin
          m_ready = 1'b1;
          if (m_readM) begin
            lbase   = {m_address[15:2], 2'b00};
            m_rdata = {mem[lbase+3], mem[lbase+2], mem[lbase+1], mem[lbase]};
          end else begin
            mem[m_address] = m_wdata;
          end
        end else begin
          mcnt++;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int          stalls;
  } exp_t;
  exp_t exp_q[$];
  exp_t me;

  bit          ref_valid [4];
  logic [11:0] ref_tag   [4];
  int exp_access = 0, exp_hits = 0, exp_mreads = 0, exp_mwrites = 0;
  int completions = 0;
  int stall_run = 0;

  // Monitor: counts stalled cycles of the current request and checks each
  // completion against the oldest expected entry.
  always @(negedge Clk) begin
    if (Reset_N) stall_run = 0;
    else if (d_readM || d_writeM) begin
      if (d_stall) stall_run++;
      else begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_completion: addr %0h with no pending access", d_address);
        end else begin
          me = exp_q.pop_front();
          chk("stall_cycles", 64'(stall_run), 64'(me.stalls));
          if (me.is_rd) chk("d_rdata", {48'd0, d_rdata}, {48'd0, me.data});
        end
        stall_run = 0;
        completions++;
      end
    end
  end

  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wd, input int l);
    int   idx;
    bit   hit;
    exp_t e;
    int   c0, n;
    idx = int'(addr[3:2]);
    hit = ref_valid[idx] && (ref_tag[idx] == addr[15:4]);
    e.is_rd  = !wr;
    e.data   = ref_mem[addr];
    e.stalls = (wr || !hit) ? l : 0;
    exp_access++;
    if (wr) begin
      ref_mem[addr] = wd;
      exp_mwrites++;
    end else if (hit) exp_hits++;
    else begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = addr[15:4];
      exp_mreads++;
    end
    exp_q.push_back(e);
    lat = l; cur_addr = addr; cur_wdata = wd;
    d_readM = !wr; d_writeM = wr; d_address = addr; d_wdata = wd;
    c0 = completions; n = 0;
    while (completions == c0 && n < 40) begin
      @(posedge Clk);
      n++;
    end
    #1;
    if (completions == c0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no completion for addr %0h after %0d cycles", addr, n);
      exp_q.delete();
    end
    d_readM = 1'b0; d_writeM = 1'b0;
    chk("access_count", {48'd0, access_count}, 64'(exp_access));
    chk("hit_count", {48'd0, hit_count}, 64'(exp_hits));
    chk("mem_reads", 64'(mem_reads), 64'(exp_mreads));
    chk("mem_writes", 64'(mem_writes), 64'(exp_mwrites));
  endtask

  initial begin
    Reset_N = 1'b1;
    d_readM = 1'b0; d_writeM = 1'b0; d_address = '0; d_wdata = '0;
    m_ready = 1'b0; m_rdata = '0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16'h0010] = 16'h1111; mem[16'h0011] = 16'h2222;
    mem[16'h0012] = 16'h3333; mem[16'h0013] = 16'h4444;
    for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = mem[i];

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_d_stall", {63'd0, d_stall}, 64'd0);
    chk("rst_d_rdata", {48'd0, d_rdata}, 64'd0);
    chk("rst_m_readM", {63'd0, m_readM}, 64'd0);
    chk("rst_m_writeM", {63'd0, m_writeM}, 64'd0);
    chk("rst_m_address", {48'd0, m_address}, 64'd0);
    chk("rst_m_wdata", {48'd0, m_wdata}, 64'd0);
    chk("rst_access_count", {48'd0, access_count}, 64'd0);
    chk("rst_hit_count", {48'd0, hit_count}, 64'd0);
    Reset_N = 1'b0;
    mem_en  = 1'b1;
    @(posedge Clk);
    #1;

    // Directed sequence
    access(1'b0, 16'h0013, 16'h0000, 3);  // cold miss -> 0x4444
    access(1'b0, 16'h0011, 16'h0000, 3);  // hit -> 0x2222
    access(1'b1, 16'h0011, 16'hBEEF, 2);  // write hit
    access(1'b0, 16'h0011, 16'h0000, 1);  // hit -> 0xBEEF
    access(1'b1, 16'h0120, 16'h5555, 2);  // write miss, no allocate
    access(1'b0, 16'h0120, 16'h0000, 3);  // read miss -> 0x5555
    access(1'b0, 16'h0010, 16'h0000, 2);  // conflict miss
    access(1'b0, 16'h0110, 16'h0000, 2);  // conflict miss
    access(1'b0, 16'h0010, 16'h0000, 1);  // miss again
    access(1'b0, 16'h0012, 16'h0000, 4);  // hit in refilled line

    // Reset in the 2nd cycle of a read miss
    lat = 6; cur_addr = 16'h0024;
    d_readM = 1'b1; d_address = 16'h0024;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("pre_rst_m_readM", {63'd0, m_readM}, 64'd1);
    mem_en = 1'b0; Reset_N = 1'b1; d_readM = 1'b0;
    #1;
    chk("midrst_m_readM", {63'd0, m_readM}, 64'd0);
    chk("midrst_d_stall", {63'd0, d_stall}, 64'd0);
    chk("midrst_access_count", {48'd0, access_count}, 64'd0);
    chk("midrst_hit_count", {48'd0, hit_count}, 64'd0);
    chk("midrst_m_address", {48'd0, m_address}, 64'd0);
    for (int i = 0; i < 4; i++) ref_valid[i] = 1'b0;
    exp_access = 0; exp_hits = 0; exp_mreads = 0; exp_mwrites = 0;
    mem_reads = 0; mem_writes = 0; mcnt = 0;
    @(posedge Clk); #1;
    Reset_N = 1'b0;
    @(posedge Clk); #1;
    m_ready = 1'b1; m_rdata = {$urandom, $urandom};  // stray completion in IDLE
    @(posedge Clk); #1;
    m_ready = 1'b0;
    chk("stray_m_readM", {63'd0, m_readM}, 64'd0);
    chk("stray_m_writeM", {63'd0, m_writeM}, 64'd0);
    chk("stray_access_count", {48'd0, access_count}, 64'd0);
    mem_en = 1'b1;
    access(1'b0, 16'h0024, 16'h0000, 2);  // must miss: valid bits were cleared
    access(1'b0, 16'h0013, 16'h0000, 2);  // index 0 also cleared -> miss
    access(1'b0, 16'h0024, 16'h0000, 2);  // now a hit

    // Randomized traffic over a small tag pool to exercise hits and conflicts
    for (int k = 0; k < 300; k++) begin
      logic [15:0] a;
      bit          w;
      int          gap;
      a   = 16'(($urandom_range(0, 5) << 4) | $urandom_range(0, 15));
      w   = ($urandom_range(0, 9) < 3);
      access(w, a, 16'($urandom), int'($urandom_range(1, 4)));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge Clk);
        #1;
      end
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
